// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions: transfer type, response and size codes,
// plus the state encoding used by the memory slave FSM.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // Slave FSM encoding, kept as plain constants so older code can reuse it
   typedef logic [1:0] slave_state_t;
   localparam slave_state_t ST_IDLE = 2'd0;
   localparam slave_state_t ST_WAIT = 2'd1;
   localparam slave_state_t ST_ERR1 = 2'd2;
   localparam slave_state_t ST_ERR2 = 2'd3;

   // NONSEQ and SEQ are the only transfer types that carry an address phase
   function automatic logic htrans_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-lite bus bundle between the decoder/master side and one memory slave.
// Hready is the bus-wide ready coming back from the response multiplexer.
interface ahb_slave_mem_if;

   logic        Hsel;
   logic [31:0] Haddr;
   logic [1:0]  Htrans;
   logic        Hwrite;
   logic [2:0]  Hsize;
   logic [31:0] Hwdata;
   logic        Hready;
   logic        Hreadyout;
   logic        Hresp;
   logic [31:0] Hrdata;

   modport master (
      output Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hready,
      input  Hreadyout, Hresp, Hrdata
   );

   modport slave (
      input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hready,
      output Hreadyout, Hresp, Hrdata
   );

endinterface

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane decoder for a 32-bit AHB data bus.
// Produces the lane strobe for a transfer and flags misaligned halfword/word
// accesses. Sizes above word give no lanes and no misalign flag; callers
// treat those sizes as errors on their own.
module ahb_byte_strobe
   import ahb_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr,
   output logic [3:0] strb,
   output logic       misalign
);

   // Map size and low address bits onto the active byte lanes
   always_comb begin
      strb     = 4'b0000;
      misalign = 1'b0;
      case (size)
         HSIZE_BYTE: begin
            strb = 4'b0001 << addr;
         end
         HSIZE_HALF: begin
            strb     = addr[1] ? 4'b1100 : 4'b0011;
            misalign = addr[0];
         end
         HSIZE_WORD: begin
            strb     = 4'b1111;
            misalign = (addr != 2'b00);
         end
         default: begin
            strb     = 4'b0000;
            misalign = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-lite memory slave: MEM_DEPTH 32-bit words, WAIT_STATES wait cycles per
// OKAY transfer. Optional macro AHB_SLAVE_ERR_EN enables the two-cycle ERROR
// response; without it, bad transfers complete as OKAY but writes are dropped
// and reads return zero.
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input logic           Hclk,
   input logic           Hreset,
   ahb_slave_mem_if.slave bus
);

   localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   slave_state_t     state_q;
   slave_state_t     state_d;
   logic [3:0]       cnt_q;
   logic [3:0]       cnt_d;
   logic             pend_q;
   logic             pend_d;
   logic [IDX_W-1:0] idx_q;
   logic             write_q;
   logic             err_q;
   logic [3:0]       strb_q;

   logic [31:0]      mem [MEM_DEPTH];

   logic [3:0]       bus_strb;
   logic             bus_misalign;
   logic             accept;
   logic             addr_err;
   logic             mem_we;

   ahb_byte_strobe u_strobe (
      .size     (bus.Hsize),
      .addr     (bus.Haddr[1:0]),
      .strb     (bus_strb),
      .misalign (bus_misalign)
   );

   // An address phase only lands while no data phase of ours is stalling
   assign accept = bus.Hsel && bus.Hready && htrans_active(bus.Htrans) &&
                   ((state_q == ST_IDLE) || (state_q == ST_ERR2));

   assign addr_err = ({2'b00, bus.Haddr[31:2]} >= 32'(MEM_DEPTH)) ||
                     (bus.Hsize > HSIZE_WORD) || bus_misalign;

   // pend_q marks the completion cycle of an OKAY data phase
   assign mem_we = pend_q && write_q && !err_q;

   // Next-state logic: wait countdown, error sequence and new address phases
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
               pend_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`ifdef AHB_SLAVE_ERR_EN
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (accept) begin
`ifdef AHB_SLAVE_ERR_EN
         if (addr_err) begin
            state_d = ST_ERR1;
            pend_d  = 1'b0;
         end else
`endif
         if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
         end else begin
            state_d = ST_IDLE;
            pend_d  = 1'b1;
         end
      end
   end

   // FSM registers and the captured address-phase attributes
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 1'b0;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         strb_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         if (accept) begin
            idx_q   <= bus.Haddr[IDX_W+1:2];
            write_q <= bus.Hwrite;
            err_q   <= addr_err;
            strb_q  <= bus_strb;
         end
      end
   end

   // Word array; commits enabled byte lanes on the completion edge of a write
   always_ff @(posedge Hclk) begin
      if (mem_we && !Hreset) begin
         for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) begin
               mem[idx_q][8*b +: 8] <= bus.Hwdata[8*b +: 8];
            end
         end
      end
   end

   // Read data is only driven during the completion cycle of a good read
   always_comb begin
      bus.Hrdata = 32'h0000_0000;
      if (pend_q && !write_q && !err_q) begin
         bus.Hrdata = mem[idx_q];
      end
   end

   assign bus.Hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));

`ifdef AHB_SLAVE_ERR_EN
   assign bus.Hresp = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
   assign bus.Hresp = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Testbench for ahb_slave_mem: one instance with no wait states and one with
// two, driven by a pipelined bus driver and checked against a byte-level
// memory model. Honours AHB_SLAVE_ERR_EN when it is defined for the build.
module tb_ahb_slave_mem;
   import ahb_pkg::*;

`ifdef AHB_SLAVE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int DEPTH = 256;

   localparam int K_XFER  = 0;
   localparam int K_IDLE  = 1;
   localparam int K_BUSY  = 2;
   localparam int K_NOSEL = 3;

   typedef struct {
      int          kind;
      bit          write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          has_exp;
      logic [31:0] exp_data;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] model0 [int];
   logic [31:0] model1 [int];

   ahb_slave_mem_if bus0 ();
   ahb_slave_mem_if bus1 ();

   assign bus0.Hready = bus0.Hreadyout;
   assign bus1.Hready = bus1.Hreadyout;

   ahb_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .Hclk   (clk),
      .Hreset (rst),
      .bus    (bus0)
   );

   ahb_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_STATES(2)) dut1 (
      .Hclk   (clk),
      .Hreset (rst),
      .bus    (bus1)
   );

   // Free-running bus clock
   always #5 clk = ~clk;

   // Hard stop in case the bench itself wedges
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit isErr(input logic [31:0] addr, input logic [2:0] size);
      int nbytes;
      if (size > 3'd2) return 1'b1;
      if ((addr >> 2) >= DEPTH) return 1'b1;
      nbytes = 1 << size;
      return (addr % nbytes) != 0;
   endfunction

   function automatic logic [31:0] modelRead(input int which, input int idx);
      if (which == 0) return model0.exists(idx) ? model0[idx] : 32'hxxxx_xxxx;
      return model1.exists(idx) ? model1[idx] : 32'hxxxx_xxxx;
   endfunction

   function automatic void modelWrite(input int which, input logic [31:0] addr,
                                      input logic [2:0] size, input logic [31:0] wdata);
      logic [31:0] word;
      int idx;
      int off;
      int nbytes;
      idx    = int'(addr >> 2);
      off    = int'(addr % 4);
      nbytes = 1 << size;
      word   = modelRead(which, idx);
      for (int i = 0; i < nbytes; i++) word[8*(off+i) +: 8] = wdata[8*(off+i) +: 8];
      if (which == 0) model0[idx] = word;
      else            model1[idx] = word;
   endfunction

   function automatic txn_t mk(input bit w, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
      txn_t t;
      t.kind = K_XFER; t.write = w; t.addr = addr; t.size = size; t.wdata = wdata;
      t.has_exp = 1'b0; t.exp_data = 32'h0;
      return t;
   endfunction

   function automatic txn_t mkRd(input logic [31:0] addr, input logic [31:0] exp);
      txn_t t;
      t = mk(1'b0, addr, HSIZE_WORD, 32'h0);
      t.has_exp = 1'b1; t.exp_data = exp;
      return t;
   endfunction

   function automatic txn_t mkGap(input int kind);
      txn_t t;
      t = mk(1'b0, 32'h0000_0010, HSIZE_WORD, 32'h0);
      t.kind = kind;
      return t;
   endfunction

   task automatic driveAddr(input int which, input txn_t t, input bit have);
      logic        sel;
      logic [1:0]  tr;
      logic [31:0] addr;
      sel = 1'b0; tr = HTRANS_IDLE; addr = 32'h0;
      if (have) begin
         addr = t.addr;
         case (t.kind)
            K_XFER:  begin sel = 1'b1; tr = HTRANS_NONSEQ; end
            K_IDLE:  begin sel = 1'b1; tr = HTRANS_IDLE;   end
            K_BUSY:  begin sel = 1'b1; tr = HTRANS_BUSY;   end
            default: begin sel = 1'b0; tr = HTRANS_NONSEQ; end
         endcase
      end
      if (which == 0) begin
         bus0.Hsel = sel; bus0.Haddr = addr; bus0.Htrans = tr;
         bus0.Hwrite = have && t.write; bus0.Hsize = have ? t.size : HSIZE_WORD;
      end else begin
         bus1.Hsel = sel; bus1.Haddr = addr; bus1.Htrans = tr;
         bus1.Hwrite = have && t.write; bus1.Hsize = have ? t.size : HSIZE_WORD;
      end
   endtask

   task automatic driveWdata(input int which, input logic [31:0] d);
      if (which == 0) bus0.Hwdata = d;
      else            bus1.Hwdata = d;
   endtask

   task automatic sampleBus(input int which, output logic rdy, output logic resp,
                            output logic [31:0] rdata);
      if (which == 0) begin rdy = bus0.Hreadyout; resp = bus0.Hresp; rdata = bus0.Hrdata; end
      else            begin rdy = bus1.Hreadyout; resp = bus1.Hresp; rdata = bus1.Hrdata; end
   endtask

   // Pipelined master: address of the next transfer overlaps the data phase
   task automatic applyStimulus(input int which, input txn_t q[$]);
      txn_t        a;
      txn_t        d;
      bit          have_a;
      bit          have_d;
      bit          err;
      int          dlen;
      int          ws;
      int          budget;
      int          limit;
      logic        rdy;
      logic        resp;
      logic [31:0] rdata;
      logic [31:0] exp;
      string       tg;
      ws     = (which == 0) ? 0 : 2;
      limit  = (q.size() + 2) * 8 + 20;
      budget = 0;
      have_d = 1'b0;
      dlen   = 0;
      a      = mkGap(K_IDLE);
      d      = a;
      @(posedge clk); #1;
      have_a = q.size() > 0;
      if (have_a) a = q.pop_front();
      driveAddr(which, a, have_a);
      while ((have_a || have_d) && budget < limit) begin
         @(negedge clk);
         budget++;
         sampleBus(which, rdy, resp, rdata);
         tg = $sformatf("dut%0d a=%08h", which, d.addr);
         if (have_d) begin
            dlen++;
            err = isErr(d.addr, d.size);
            if (!rdy) begin
               checkOutput({tg, " wait_resp"}, {31'h0, resp}, {31'h0, err && ERR_EN});
               checkOutput({tg, " wait_rdata"}, rdata, 32'h0);
            end else begin
               checkOutput({tg, " len"}, dlen, (err && ERR_EN) ? 2 : 1 + ws);
               checkOutput({tg, " resp"}, {31'h0, resp}, {31'h0, err && ERR_EN});
               if (d.write) begin
                  checkOutput({tg, " wr_rdata"}, rdata, 32'h0);
                  if (!err) modelWrite(which, d.addr, d.size, d.wdata);
               end else begin
                  exp = err ? 32'h0 : modelRead(which, int'(d.addr >> 2));
                  if (!$isunknown(exp)) checkOutput({tg, " rdata"}, rdata, exp);
                  if (d.has_exp) checkOutput({tg, " rdata_const"}, rdata, d.exp_data);
               end
            end
         end else begin
            checkOutput({tg, " idle_ready"}, {31'h0, rdy}, 32'h1);
            checkOutput({tg, " idle_resp"}, {31'h0, resp}, 32'h0);
            checkOutput({tg, " idle_rdata"}, rdata, 32'h0);
         end
         @(posedge clk); #1;
         if (rdy) begin
            have_d = have_a && (a.kind == K_XFER);
            d      = a;
            dlen   = 0;
            driveWdata(which, (have_d && d.write) ? d.wdata : 32'h0);
            have_a = q.size() > 0;
            if (have_a) a = q.pop_front();
            driveAddr(which, a, have_a);
         end
      end
      if (have_a || have_d) begin
         checks++;
         failures++;
         $display("[TB] FAIL dut%0d timeout observed=pending expected=complete", which);
         have_a = 1'b0;
         driveAddr(which, a, have_a);
      end
   endtask

   initial begin
      txn_t        q[$];
      logic [31:0] saved;
      logic [31:0] addr;
      logic [2:0]  size;
      txn_t        t;

      rst = 1'b1;
      driveAddr(0, mkGap(K_IDLE), 1'b0);
      driveAddr(1, mkGap(K_IDLE), 1'b0);
      driveWdata(0, 32'h0);
      driveWdata(1, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset ready0", {31'h0, bus0.Hreadyout}, 32'h1);
      checkOutput("reset resp0", {31'h0, bus0.Hresp}, 32'h0);
      checkOutput("reset rdata0", bus0.Hrdata, 32'h0);
      checkOutput("reset ready1", {31'h0, bus1.Hreadyout}, 32'h1);
      checkOutput("reset resp1", {31'h0, bus1.Hresp}, 32'h0);
      checkOutput("reset rdata1", bus1.Hrdata, 32'h0);
      rst = 1'b0;

      $display("[TB] preloading words 0..15");
      for (int w = 0; w < 2; w++) begin
         q = {};
         for (int i = 0; i < 16; i++) q.push_back(mk(1'b1, 32'(i * 4), HSIZE_WORD, $urandom));
         applyStimulus(w, q);
      end

      $display("[TB] write then read back-to-back");
      q = {};
      q.push_back(mk(1'b1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF));
      q.push_back(mkRd(32'h10, 32'hDEAD_BEEF));
      applyStimulus(0, q);

      $display("[TB] wait-state read followed by immediate NONSEQ");
      q = {};
      q.push_back(mk(1'b1, 32'h04, HSIZE_WORD, 32'h0BAD_F00D));
      q.push_back(mkGap(K_IDLE));
      q.push_back(mkRd(32'h04, 32'h0BAD_F00D));
      q.push_back(mk(1'b0, 32'h08, HSIZE_WORD, 32'h0));
      applyStimulus(1, q);

      $display("[TB] byte lane write, out-of-range and misaligned accesses");
      for (int w = 0; w < 2; w++) begin
         q = {};
         q.push_back(mk(1'b1, 32'h20, HSIZE_WORD, 32'h1122_3344));
         q.push_back(mk(1'b1, 32'h21, HSIZE_BYTE, 32'h0000_AA00));
         q.push_back(mkRd(32'h20, 32'h1122_AA44));
         q.push_back(mkRd(32'h400, 32'h0));
         q.push_back(mk(1'b1, 32'h00, HSIZE_WORD, 32'h55AA_55AA));
         q.push_back(mk(1'b1, 32'h02, HSIZE_WORD, 32'hFFFF_FFFF));
         q.push_back(mkRd(32'h00, 32'h55AA_55AA));
         q.push_back(mkGap(K_IDLE));
         q.push_back(mkGap(K_BUSY));
         q.push_back(mkGap(K_NOSEL));
         q.push_back(mkRd(32'h20, 32'h1122_AA44));
         applyStimulus(w, q);
      end

      $display("[TB] reset during a write wait cycle");
      saved = modelRead(1, 12);
      @(posedge clk); #1;
      driveAddr(1, mk(1'b1, 32'h30, HSIZE_WORD, 32'hCAFE_F00D), 1'b1);
      @(posedge clk); #1;
      driveWdata(1, 32'hCAFE_F00D);
      driveAddr(1, mkGap(K_IDLE), 1'b0);
      @(negedge clk);
      checkOutput("rst pre ready", {31'h0, bus1.Hreadyout}, 32'h0);
      rst = 1'b1;
      #1;
      checkOutput("rst ready", {31'h0, bus1.Hreadyout}, 32'h1);
      checkOutput("rst resp", {31'h0, bus1.Hresp}, 32'h0);
      checkOutput("rst rdata", bus1.Hrdata, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      driveWdata(1, 32'h0);
      q = {};
      q.push_back(mkRd(32'h30, saved));
      applyStimulus(1, q);

      $display("[TB] randomized traffic");
      for (int w = 0; w < 2; w++) begin
         q = {};
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 2) begin
               q.push_back(mkGap($urandom_range(1, 3)));
            end else begin
               if ($urandom_range(0, 7) == 0) addr = 32'($urandom_range(256, 300)) << 2;
               else                           addr = 32'($urandom_range(0, 15)) << 2;
               addr[1:0] = 2'($urandom_range(0, 3));
               size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
               t = mk(1'($urandom_range(0, 1)), addr, size, $urandom);
               q.push_back(t);
            end
         end
         applyStimulus(w, q);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
